key_scan_debounce: RTL and testbench

KEY_SCAN_DEBOUNCE -- requirements
Module: key_scan_debounce

---
 rtl/key_scan_debounce.sv | 213 +++++++++++++++++++++
 tb/tb_key_scan_debounce.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_scan_debounce.sv
// ---------------------------------------------------------------------------
// key_scan_debounce
//   Multi-channel key debouncer with press/release edge pulses, one-shot
//   long-press detection and auto-repeat while a key stays held.
//
//   Each raw pin is resynchronised (2 flops), converted to a "pressed" bit,
//   and debounced against a shared millisecond-style tick. A per-channel FSM
//   turns the debounced level into long-press and repeat events.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   key_in       [CH] raw asynchronous key pins
//   key_level    [CH] debounced pressed state (1 = pressed)
//   key_press    [CH] one-cycle pulse on an accepted press
//   key_release  [CH] one-cycle pulse on an accepted release
//   key_long     [CH] one-cycle pulse once per press at the long-press point
//   key_repeat   [CH] one-cycle pulse every REPEAT_MS ticks after long press
//
// Per-channel FSM
//   state       | meaning
//   ST_RELEASED | key debounced as not pressed
//   ST_PRESSED  | key pressed, hold_cnt counting toward long-press point
//   ST_HELD     | long press reported, hold_cnt counting repeat interval
// ---------------------------------------------------------------------------
module key_scan_debounce #(
  parameter int CH          = 4,
  parameter int FREQ        = 50,
  parameter int TICK_CYCLES = FREQ * 1000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] key_in,
  output logic [CH-1:0] key_level,
  output logic [CH-1:0] key_press,
  output logic [CH-1:0] key_release,
  output logic [CH-1:0] key_long,
  output logic [CH-1:0] key_repeat
);

  localparam int PRE_W    = $clog2(TICK_CYCLES) + 1;
  localparam int DB_W     = $clog2(DEBOUNCE_MS) + 1;
  localparam int LONG_GAP = LONG_MS - DEBOUNCE_MS;
  localparam int HOLD_MAX = (LONG_GAP > REPEAT_MS) ? LONG_GAP : REPEAT_MS;
  localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_GAP - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((REPEAT_MS > 0) ? REPEAT_MS - 1 : 0);

  // Idle pin level; also the XOR mask that turns a pin into "pressed".
  localparam logic [CH-1:0] IDLE_LVL = {CH{(ACTIVE_LOW != 0)}};

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Synchronizers. They reset to the idle pin level so that a key held
  // through reset is seen as a fresh press once reset is released.
  // -------------------------------------------------------------------------
  logic [CH-1:0] r_sync1;
  logic [CH-1:0] r_sync2;
  logic [CH-1:0] w_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= IDLE_LVL;
      r_sync2 <= IDLE_LVL;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw = r_sync2 ^ IDLE_LVL;

  // -------------------------------------------------------------------------
  // Shared tick prescaler: 0..TICK_CYCLES-1, tick on the last count.
  // -------------------------------------------------------------------------
  logic [PRE_W-1:0] r_pre;
  logic             w_tick;

  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel debounce and press FSM.
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_long;
    logic              r_repeat;

    logic w_differs;
    logic w_accept;
    logic w_acc_press;
    logic w_acc_release;

    assign w_differs     = (w_raw[g] != r_level);
    assign w_accept      = w_tick && w_differs && (r_db_cnt == DB_LAST);
    assign w_acc_press   = w_accept && !r_level;
    assign w_acc_release = w_accept && r_level;

    // Debounce: any cycle where the raw level agrees with the accepted level
    // restarts the count, so only an uninterrupted run of ticks is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_db_cnt  <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        if (!w_differs) begin
          r_db_cnt <= '0;
        end else if (w_tick) begin
          if (r_db_cnt == DB_LAST) begin
            r_db_cnt  <= '0;
            r_level   <= ~r_level;
            r_press   <= ~r_level;
            r_release <= r_level;
          end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
          end
        end
      end
    end

    // Press FSM. The acceptance edge of a press is itself a tick and does
    // not count toward hold time; the release check comes first in every
    // state so a release landing on a threshold tick suppresses the event.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state    <= ST_RELEASED;
        r_hold_cnt <= '0;
        r_long     <= 1'b0;
        r_repeat   <= 1'b0;
      end else begin
        r_long   <= 1'b0;
        r_repeat <= 1'b0;
        case (r_state)
          ST_RELEASED: begin
            if (w_acc_press) begin
              r_state    <= ST_PRESSED;
              r_hold_cnt <= '0;
            end
          end
          ST_PRESSED: begin
            if (w_acc_release) begin
              r_state    <= ST_RELEASED;
              r_hold_cnt <= '0;
            end else if (w_tick) begin
              if (r_hold_cnt == LONG_LAST) begin
                r_state    <= ST_HELD;
                r_hold_cnt <= '0;
                r_long     <= 1'b1;
              end else begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
              end
            end
          end
          ST_HELD: begin
            if (w_acc_release) begin
              r_state    <= ST_RELEASED;
              r_hold_cnt <= '0;
            end else if ((REPEAT_MS > 0) && w_tick) begin
              if (r_hold_cnt == REP_LAST) begin
                r_hold_cnt <= '0;
                r_repeat   <= 1'b1;
              end else begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
              end
            end
          end
          default: begin
            r_state    <= ST_RELEASED;
            r_hold_cnt <= '0;
          end
        endcase
      end
    end

    assign key_level[g]   = r_level;
    assign key_press[g]   = r_press;
    assign key_release[g] = r_release;
    assign key_long[g]    = r_long;
    assign key_repeat[g]  = r_repeat;
  end

endmodule

// File: tb/tb_key_scan_debounce.sv
module tb_key_scan_debounce;

  localparam int CH       = 4;
  localparam int TB_TICK  = 10;
  localparam int TB_DB    = 3;
  localparam int TB_LONG  = 10;
  localparam int TB_REP   = 4;
  localparam int LONG_GAP = (TB_LONG - TB_DB) * TB_TICK;
  localparam int REP_GAP  = TB_REP * TB_TICK;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;
  localparam int K_REPEAT  = 3;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic [CH-1:0] key_in = '1;
  logic [CH-1:0] key_level;
  logic [CH-1:0] key_press;
  logic [CH-1:0] key_release;
  logic [CH-1:0] key_long;
  logic [CH-1:0] key_repeat;

  key_scan_debounce #(
    .CH(CH), .FREQ(50), .TICK_CYCLES(TB_TICK), .DEBOUNCE_MS(TB_DB),
    .LONG_MS(TB_LONG), .REPEAT_MS(TB_REP), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_level(key_level),
    .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int r_cyc   = 0;   // cycle index at which reset was last released

  typedef struct {
    int kind;
    int ch;
    int cyc;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;

  function automatic string kname(input int k);
    case (k)
      K_PRESS:   return "press";
      K_RELEASE: return "release";
      K_LONG:    return "long";
      default:   return "repeat";
    endcase
  endfunction

  // Ticks happen on edges R+10, R+20, ... after reset release at cycle R.
  function automatic int next_tick(input int c);
    int t = c;
    while (t <= r_cyc || ((t - r_cyc) % TB_TICK) != 0) t++;
    return t;
  endfunction

  // Pin driven just after edge k: synced value acts from edge k+3 on, and
  // the DB-th tick from there accepts the change.
  function automatic int accept_cycle(input int k);
    return next_tick(k + 3) + (TB_DB - 1) * TB_TICK;
  endfunction

  task automatic push_ev(input int k, input int c, input int t);
    ev_t e;
    e.kind = k;
    e.ch   = c;
    e.cyc  = t;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: every output pulse must match the next expected
  // event (kind, channel, exact cycle) and agree with key_level.
  logic [3:0][CH-1:0] w_pulses;
  assign w_pulses = {key_repeat, key_long, key_release, key_press};

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < CH; c++) begin
        if (w_pulses[k][c] === 1'b1) begin
          cmp_cnt++;
          if (sb.size() == 0) begin
            err_cnt++;
            $display("FAIL unexpected_event: got %s ch%0d at cycle %0d, expected no event",
                     kname(k), c, cyc);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.kind !== k || mon_e.ch !== c || mon_e.cyc !== cyc) begin
              err_cnt++;
              $display("FAIL event_order: got %s ch%0d at cycle %0d, expected %s ch%0d at cycle %0d",
                       kname(k), c, cyc, kname(mon_e.kind), mon_e.ch, mon_e.cyc);
            end
          end
          cmp_cnt++;
          if (key_level[c] !== (k != K_RELEASE)) begin
            err_cnt++;
            $display("FAIL event_level: %s ch%0d key_level=%b, expected %b",
                     kname(k), c, key_level[c], (k != K_RELEASE));
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n  = 1'b0;
    key_in = '1;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (key_level !== '0) begin
      err_cnt++; $display("FAIL reset_level: got %b, expected 0000", key_level);
    end
    cmp_cnt++;
    if ({key_press, key_release, key_long, key_repeat} !== '0) begin
      err_cnt++;
      $display("FAIL reset_pulses: got %h, expected 0", {key_press, key_release, key_long, key_repeat});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    r_cyc = cyc;
    repeat (30) @(posedge clk);
    #1;
    cmp_cnt++;
    if (key_level !== '0) begin
      err_cnt++; $display("FAIL idle_level: got %b, expected 0000", key_level);
    end
  endtask

  task automatic test_press();
    int k, m, k2, r;
    @(posedge clk); #1;
    k = cyc;
    key_in[0] = 1'b0;
    m = accept_cycle(k);
    push_ev(K_PRESS, 0, m);
    wait_until(m - 1);
    cmp_cnt++;
    if (key_level[0] !== 1'b0) begin
      err_cnt++; $display("FAIL press_early: key_level[0]=%b one cycle before accept, expected 0", key_level[0]);
    end
    wait_until(m);
    cmp_cnt++;
    if (key_press[0] !== 1'b1 || key_level[0] !== 1'b1) begin
      err_cnt++;
      $display("FAIL press_same_cycle: press=%b level=%b at cycle %0d, expected 1/1",
               key_press[0], key_level[0], cyc);
    end
    k2 = m + 20;
    wait_until(k2);
    key_in[0] = 1'b1;
    r = accept_cycle(k2);
    push_ev(K_RELEASE, 0, r);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    cmp_cnt++;
    if (sb.size() != 0) begin
      err_cnt++; $display("FAIL press_drain: %0d events pending, expected 0", sb.size());
    end
    sb.delete();
    repeat (50) @(posedge clk);
    #1;
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 14; i++) begin
      key_in[1] = ~key_in[1];
      repeat (15) @(posedge clk);
      #1;
      cmp_cnt++;
      if (key_level[1] !== 1'b0) begin
        err_cnt++; $display("FAIL bounce_level: key_level[1]=%b at toggle %0d, expected 0", key_level[1], i);
      end
    end
    key_in[1] = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    cmp_cnt++;
    if (key_level[1] !== 1'b0) begin
      err_cnt++; $display("FAIL bounce_rest: key_level[1]=%b, expected 0", key_level[1]);
    end
  endtask

  task automatic test_simultaneous();
    int k, m, k2, r;
    @(posedge clk); #1;
    k = cyc;
    key_in[0] = 1'b0;
    key_in[3] = 1'b0;
    m = accept_cycle(k);
    push_ev(K_PRESS, 0, m);
    push_ev(K_PRESS, 3, m);
    wait_until(m);
    cmp_cnt++;
    if (key_press[0] !== 1'b1 || key_press[3] !== 1'b1) begin
      err_cnt++; $display("FAIL simul_press: key_press=%b at cycle %0d, expected 1xx1", key_press, cyc);
    end
    k2 = m + 10;
    wait_until(k2);
    key_in[0] = 1'b1;
    key_in[3] = 1'b1;
    r = accept_cycle(k2);
    push_ev(K_RELEASE, 0, r);
    push_ev(K_RELEASE, 3, r);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    cmp_cnt++;
    if (sb.size() != 0) begin
      err_cnt++; $display("FAIL simul_drain: %0d events pending, expected 0", sb.size());
    end
    sb.delete();
    repeat (50) @(posedge clk);
    #1;
  endtask

  task automatic test_long_repeat();
    int k, m, k2, r, t;
    @(posedge clk); #1;
    k  = cyc;
    k2 = k + 200 * TB_TICK;
    key_in[2] = 1'b0;
    m = accept_cycle(k);
    r = accept_cycle(k2);
    push_ev(K_PRESS, 2, m);
    push_ev(K_LONG, 2, m + LONG_GAP);
    t = m + LONG_GAP + REP_GAP;
    while (t < r) begin
      push_ev(K_REPEAT, 2, t);
      t += REP_GAP;
    end
    wait_until(k2);
    key_in[2] = 1'b1;
    push_ev(K_RELEASE, 2, r);
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    cmp_cnt++;
    if (sb.size() != 0) begin
      err_cnt++; $display("FAIL long_drain: %0d events pending, expected 0", sb.size());
    end
    sb.delete();
    repeat (200) @(posedge clk);
    #1;
    cmp_cnt++;
    if (key_level[2] !== 1'b0) begin
      err_cnt++; $display("FAIL long_after_release: key_level[2]=%b, expected 0", key_level[2]);
    end
  endtask

  task automatic test_release_at_threshold();
    int k, m, r;
    @(posedge clk); #1;
    k = cyc;
    key_in[3] = 1'b0;
    m = accept_cycle(k);
    push_ev(K_PRESS, 3, m);
    wait_until(m + LONG_GAP - 23);
    key_in[3] = 1'b1;
    r = accept_cycle(cyc);
    push_ev(K_RELEASE, 3, r);
    wait_until(m + LONG_GAP);
    cmp_cnt++;
    if (key_release[3] !== 1'b1 || key_long[3] !== 1'b0) begin
      err_cnt++;
      $display("FAIL release_wins: release=%b long=%b at cycle %0d, expected 1/0",
               key_release[3], key_long[3], cyc);
    end
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    cmp_cnt++;
    if (sb.size() != 0) begin
      err_cnt++; $display("FAIL thresh_drain: %0d events pending, expected 0", sb.size());
    end
    sb.delete();
    repeat (100) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_hold();
    int k, m, k2, r;
    @(posedge clk); #1;
    k = cyc;
    key_in[2] = 1'b0;
    m = accept_cycle(k);
    push_ev(K_PRESS, 2, m);
    push_ev(K_LONG, 2, m + LONG_GAP);
    wait_until(m + LONG_GAP + 20);
    cmp_cnt++;
    if (key_level[2] !== 1'b1 || sb.size() != 0) begin
      err_cnt++;
      $display("FAIL hold_before_reset: key_level[2]=%b pending=%0d, expected 1/0", key_level[2], sb.size());
    end
    rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (key_level !== '0) begin
      err_cnt++; $display("FAIL midreset_level: got %b, expected 0000", key_level);
    end
    cmp_cnt++;
    if ({key_press, key_release, key_long, key_repeat} !== '0) begin
      err_cnt++;
      $display("FAIL midreset_pulses: got %h, expected 0", {key_press, key_release, key_long, key_repeat});
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    r_cyc = cyc;
    m = accept_cycle(r_cyc);
    push_ev(K_PRESS, 2, m);
    push_ev(K_LONG, 2, m + LONG_GAP);
    wait_until(m + LONG_GAP + 5);
    k2 = cyc;
    key_in[2] = 1'b1;
    r = accept_cycle(k2);
    push_ev(K_RELEASE, 2, r);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    cmp_cnt++;
    if (sb.size() != 0) begin
      err_cnt++; $display("FAIL rehold_drain: %0d events pending, expected 0", sb.size());
    end
    sb.delete();
    repeat (100) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_simultaneous();
    test_long_repeat();
    test_release_at_threshold();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
